// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter/sequencer that time-shares one combinational adder among NREQ requesters.
// Latency: request accepted at edge T, rsp_valid high after edge T+1; at best one transaction every 3 cycles.
// Backpressure: the response is held stable until rsp_ready; no new grant while a transaction is in flight.
module adder_share_arbiter #(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [N-1:0]      add_in1,
    output logic [N-1:0]      add_in2,
    input  logic [N-1:0]      add_answer,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_sum,
    output logic [IDW-1:0]    rsp_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] held_id_q, held_id_d;
    logic [N-1:0]   in1_q, in1_d;
    logic [N-1:0]   in2_q, in2_d;
    logic [N-1:0]   sum_q, sum_d;
    logic [IDW-1:0] rid_q, rid_d;
    logic           rvld_q, rvld_d;

    logic           found;
    logic [IDW-1:0] win;
    logic [IDW-1:0] scan_idx;

    // Round-robin search: first valid requester starting at ptr, wrapping modulo NREQ.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = ptr_q + IDW'(k);
            if (!found && req_valid[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end
    end

    // Grant is only offered in IDLE; held low while reset is asserted so nothing is accepted then.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == IDLE) && found) begin
            req_ready = NREQ'(1) << win;
        end
    end

    // Next-state and datapath updates for the IDLE/CALC/RESP sequence.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        held_id_d = held_id_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        sum_d     = sum_q;
        rid_d     = rid_q;
        rvld_d    = rvld_q;
        unique case (state_q)
            IDLE: begin
                // The winner's valid is high by construction, so a found winner is a handshake.
                if (found) begin
                    in1_d     = req_a[int'(win)*N +: N];
                    in2_d     = req_b[int'(win)*N +: N];
                    held_id_d = win;
                    ptr_d     = win + IDW'(1);
                    state_d   = CALC;
                end
            end
            CALC: begin
                // Operands have been stable for a full cycle; capture the adder result.
                sum_d   = add_answer;
                rid_d   = held_id_q;
                rvld_d  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rvld_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            held_id_q <= '0;
            in1_q     <= '0;
            in2_q     <= '0;
            sum_q     <= '0;
            rid_q     <= '0;
            rvld_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            held_id_q <= held_id_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            sum_q     <= sum_d;
            rid_q     <= rid_d;
            rvld_q    <= rvld_d;
        end
    end

    assign add_in1   = in1_q;
    assign add_in2   = in2_q;
    assign rsp_valid = rvld_q;
    assign rsp_sum   = sum_q;
    assign rsp_id    = rid_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Testbench for adder_share_arbiter: directed scenarios plus randomized traffic.
// Expected responses come from a round-robin reference model feeding a scoreboard queue.
// Responses are popped and compared by an independent monitor on each response handshake.
module tb_adder_share_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [N-1:0]      add_in1;
    logic [N-1:0]      add_in2;
    logic [N-1:0]      add_answer;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [N-1:0]      rsp_sum;
    logic [IDW-1:0]    rsp_id;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [N-1:0]   sum;
    } exp_t;

    exp_t sbq[$];
    exp_t rsp_log[$];

    int tests = 0;
    int fails = 0;

    // reference model state
    int             m_ptr;
    bit             m_calc;
    bit             m_pend;
    logic [N-1:0]   m_in1;
    logic [N-1:0]   m_in2;
    int             m_g;
    int             m_idx;
    int             m_sum;
    logic [NREQ-1:0] m_rdy;
    logic [N-1:0]   m_a;
    logic [N-1:0]   m_b;
    logic [NREQ-1:0] hs;

    adder_share_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .add_in1    (add_in1),
        .add_in2    (add_in2),
        .add_answer (add_answer),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_id     (rsp_id)
    );

    // the shared adder the arbiter drives
    assign add_answer = add_in1 + add_in2;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // Reference model: checks per-cycle outputs, then predicts the coming edge.
    always @(negedge clk) begin
        hs = req_valid & req_ready;
        if (!rst_n) begin
            sbq.delete();
            m_ptr  = 0;
            m_calc = 0;
            m_pend = 0;
            m_in1  = '0;
            m_in2  = '0;
            check("rst_req_ready", 32'(req_ready), 32'(0));
            check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
            check("rst_rsp_sum",   32'(rsp_sum),   32'(0));
            check("rst_rsp_id",    32'(rsp_id),    32'(0));
            check("rst_add_in1",   32'(add_in1),   32'(0));
            check("rst_add_in2",   32'(add_in2),   32'(0));
        end else begin
            m_g   = -1;
            m_rdy = '0;
            if (!m_calc && !m_pend) begin
                for (int k = 0; k < NREQ; k++) begin
                    m_idx = (m_ptr + k) % NREQ;
                    if (m_g < 0 && req_valid[m_idx]) m_g = m_idx;
                end
            end
            if (m_g >= 0) m_rdy[m_g] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(m_rdy));
            check("req_ready_onehot0", 32'($onehot0(req_ready)), 32'(1));
            check("rsp_valid", 32'(rsp_valid), 32'(m_pend));
            check("add_in1", 32'(add_in1), 32'(m_in1));
            check("add_in2", 32'(add_in2), 32'(m_in2));
            if (m_pend && rsp_ready) begin
                m_pend = 0;
            end else if (m_calc) begin
                m_calc = 0;
                m_pend = 1;
            end else if (m_g >= 0) begin
                m_a    = req_a[m_g*N +: N];
                m_b    = req_b[m_g*N +: N];
                m_sum  = (int'(m_a) + int'(m_b)) % (1 << N);
                sbq.push_back('{id: IDW'(m_g), sum: N'(m_sum)});
                m_in1  = m_a;
                m_in2  = m_b;
                m_ptr  = (m_g + 1) % NREQ;
                m_calc = 1;
            end
        end
    end

    // Monitor: compare every presented response against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sbq.size() == 0) begin
                fail_now($sformatf("rsp_unexpected id=%0d sum=0x%0h", rsp_id, rsp_sum));
            end else begin
                check("rsp_id",  32'(rsp_id),  32'(sbq[0].id));
                check("rsp_sum", 32'(rsp_sum), 32'(sbq[0].sum));
                if (rsp_ready) begin
                    rsp_log.push_back('{id: rsp_id, sum: rsp_sum});
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_one(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        bit done;
        done = 0;
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
        req_valid[i]    = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (req_ready[i]) done = 1;
        end
        if (!done) fail_now($sformatf("grant_timeout req%0d", i));
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsps(input int n);
        for (int c = 0; c < 500 && rsp_log.size() < n; c++) @(negedge clk);
        if (rsp_log.size() < n) fail_now($sformatf("rsp_timeout have %0d want %0d", rsp_log.size(), n));
        tick();
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 1000 && (sbq.size() != 0 || rsp_valid); c++) @(negedge clk);
        if (sbq.size() != 0) fail_now($sformatf("drain_timeout pending %0d", sbq.size()));
        tick();
    endtask

    task automatic chk_log(input int idx, input int id, input int sum);
        if (idx >= rsp_log.size()) begin
            fail_now($sformatf("log_missing idx %0d", idx));
        end else begin
            check($sformatf("log%0d_id", idx),  32'(rsp_log[idx].id),  32'(id));
            check($sformatf("log%0d_sum", idx), 32'(rsp_log[idx].sum), 32'(sum));
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_log.delete();
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        bit got;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tick();
        do_reset();

        // single requests, including modulo-2^N wrap
        req_one(0, 8'd230, 8'd10);
        wait_rsps(1);
        chk_log(0, 0, 240);
        req_one(2, 8'd255, 8'd1);
        wait_rsps(2);
        chk_log(1, 2, 0);
        req_one(1, 8'd100, 8'd200);
        wait_rsps(3);
        chk_log(2, 1, 44);
        req_one(3, 8'hFF, 8'hFD);
        wait_rsps(4);
        chk_log(3, 3, 8'hFC);
        wait_drain();

        // all requesters valid continuously from reset
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = N'(i);
            req_b[i*N +: N] = 8'd10;
        end
        req_valid = '1;
        wait_rsps(5);
        req_valid = '0;
        chk_log(0, 0, 10);
        chk_log(1, 1, 11);
        chk_log(2, 2, 12);
        chk_log(3, 3, 13);
        chk_log(4, 0, 10);
        wait_drain();

        // back-pressure plus fairness after a grant to requester 1
        do_reset();
        rsp_ready = 1'b0;
        req_one(1, 8'd5, 8'd6);
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        if (!got) fail_now("bp_rsp_valid_timeout");
        tick();
        fork
            req_one(0, 8'd7, 8'd8);
            req_one(3, 8'd9, 8'd9);
            begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check("bp_rsp_valid", 32'(rsp_valid), 32'(1));
                    check("bp_rsp_sum",   32'(rsp_sum),   32'(11));
                    check("bp_rsp_id",    32'(rsp_id),    32'(1));
                    check("bp_req_ready", 32'(req_ready), 32'(0));
                end
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        wait_rsps(3);
        chk_log(0, 1, 11);
        chk_log(1, 3, 18);
        chk_log(2, 0, 15);
        wait_drain();

        // reset asserted while a transaction is in CALC
        do_reset();
        req_a[2*N +: N] = 8'd33;
        req_b[2*N +: N] = 8'd44;
        req_valid[2]    = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = req_ready[2];
        end
        if (!got) fail_now("midrst_grant_timeout");
        tick();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_log.delete();
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("midrst_rsp_sum",   32'(rsp_sum),   32'(0));
        check("midrst_rsp_id",    32'(rsp_id),    32'(0));
        check("midrst_add_in1",   32'(add_in1),   32'(0));
        check("midrst_add_in2",   32'(add_in2),   32'(0));
        check("midrst_req_ready", 32'(req_ready), 32'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        fork
            req_one(1, 8'd20, 8'd22);
            req_one(3, 8'd50, 8'd60);
        join
        wait_rsps(2);
        chk_log(0, 1, 42);
        chk_log(1, 3, 110);
        wait_drain();

        // randomized traffic with random response back-pressure
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_a[i*N +: N] = N'($urandom);
                    req_b[i*N +: N] = N'($urandom);
                    req_valid[i]    = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_drain();
        check("final_queue_empty", 32'(sbq.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
